// File: rtl/present_codec_core_pkg.sv
// Shared PRESENT constants, state encoding and the round-layer helper functions.
package present_pkg;

  localparam int ROUNDS  = 31;
  localparam int BLOCK_W = 64;

  // Nibble i of each table holds S(i) and S^-1(i).
  localparam logic [63:0] SBOX     = 64'h21748FE3DA09B65C;
  localparam logic [63:0] INV_SBOX = 64'hA970364BD21C8FE5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    KEXP = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_e;

  function automatic logic [3:0] sbox4(input logic [3:0] x);
    return SBOX[{x, 2'b00} +: 4];
  endfunction

  function automatic logic [3:0] inv_sbox4(input logic [3:0] x);
    return INV_SBOX[{x, 2'b00} +: 4];
  endfunction

  function automatic logic [BLOCK_W-1:0] sbox_layer(input logic [BLOCK_W-1:0] s);
    logic [BLOCK_W-1:0] r;
    for (int n = 0; n < 16; n++) r[4*n +: 4] = sbox4(s[4*n +: 4]);
    return r;
  endfunction

  function automatic logic [BLOCK_W-1:0] inv_sbox_layer(input logic [BLOCK_W-1:0] s);
    logic [BLOCK_W-1:0] r;
    for (int n = 0; n < 16; n++) r[4*n +: 4] = inv_sbox4(s[4*n +: 4]);
    return r;
  endfunction

  // Bit i moves to position 16*(i mod 4) + i/4.
  function automatic logic [BLOCK_W-1:0] p_layer(input logic [BLOCK_W-1:0] s);
    logic [BLOCK_W-1:0] r;
    for (int i = 0; i < BLOCK_W; i++) r[16*(i%4) + i/4] = s[i];
    return r;
  endfunction

  function automatic logic [BLOCK_W-1:0] inv_p_layer(input logic [BLOCK_W-1:0] s);
    logic [BLOCK_W-1:0] r;
    for (int i = 0; i < BLOCK_W; i++) r[i] = s[16*(i%4) + i/4];
    return r;
  endfunction

endpackage

// File: rtl/present_codec_core_if.sv
// Request/response bus of the PRESENT engine.
// Handshake: a transfer happens on a rising edge where valid && ready; the
// producer holds valid and its payload stable until that edge, and ready may
// not depend combinationally on valid.
interface present_codec_core_if #(
  parameter int KEY_LEN = 128
);
  logic               in_valid;
  logic               in_ready;
  logic               in_mode;
  logic [63:0]        in_data;
  logic [KEY_LEN-1:0] in_key;
  logic               out_valid;
  logic               out_ready;
  logic [63:0]        out_data;

  modport master (
    output in_valid, in_mode, in_data, in_key, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_mode, in_data, in_key, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/present_codec_core_key_step.sv
// One PRESENT key-schedule step, forward (dir=0) or its exact inverse (dir=1).
module present_key_step
  import present_pkg::*;
#(
  parameter int KEY_LEN = 128
) (
  input  logic [KEY_LEN-1:0] key,
  input  logic [4:0]         counter,
  input  logic               dir,
  output logic [KEY_LEN-1:0] next_key
);

  logic [KEY_LEN-1:0] fwd_rot;
  logic [KEY_LEN-1:0] fwd_key;
  logic [KEY_LEN-1:0] inv_mix;
  logic [KEY_LEN-1:0] inv_key;

  assign fwd_rot = (key << 61) | (key >> (KEY_LEN - 61));

  if (KEY_LEN == 80) begin : g_k80
    // 80-bit: one S-box on the top nibble, counter into bits 19:15
    always_comb begin
      fwd_key          = fwd_rot;
      fwd_key[79:76]   = sbox4(fwd_rot[79:76]);
      fwd_key[19:15]   = fwd_rot[19:15] ^ counter;
      inv_mix          = key;
      inv_mix[19:15]   = key[19:15] ^ counter;
      inv_mix[79:76]   = inv_sbox4(key[79:76]);
    end
  end else begin : g_k128
    // 128-bit: two S-boxes on the top byte, counter into bits 66:62
    always_comb begin
      fwd_key          = fwd_rot;
      fwd_key[127:124] = sbox4(fwd_rot[127:124]);
      fwd_key[123:120] = sbox4(fwd_rot[123:120]);
      fwd_key[66:62]   = fwd_rot[66:62] ^ counter;
      inv_mix          = key;
      inv_mix[66:62]   = key[66:62] ^ counter;
      inv_mix[127:124] = inv_sbox4(key[127:124]);
      inv_mix[123:120] = inv_sbox4(key[123:120]);
    end
  end

  assign inv_key  = (inv_mix >> 61) | (inv_mix << (KEY_LEN - 61));
  assign next_key = dir ? inv_key : fwd_key;

endmodule

// File: rtl/present_codec_core.sv
// Iterative PRESENT encrypt/decrypt engine, one round per clock, with an
// optional cache of the last decryption key and its final round key K32.
module present_codec_core
  import present_pkg::*;
#(
  parameter int KEY_LEN   = 128,
  parameter int KEY_CACHE = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  present_codec_core_if.slave       bus,
  output logic                      busy,
  output state_e                    dbg_state
);

  if (!(KEY_LEN == 80 || KEY_LEN == 128)) begin : g_bad_key_len
    $error("present_codec_core: KEY_LEN must be 80 or 128");
  end

  state_e               state_q, state_d;
  logic [4:0]           cnt_q, cnt_d;
  logic                 mode_q, mode_d;
  logic [BLOCK_W-1:0]   data_q, data_d;
  logic [KEY_LEN-1:0]   key_q, key_d;
  logic                 cache_valid_q, cache_valid_d;
  logic [KEY_LEN-1:0]   cache_key_q, cache_key_d;
  logic [KEY_LEN-1:0]   cache_k32_q, cache_k32_d;
  logic                 out_valid_q, out_valid_d;
  logic [BLOCK_W-1:0]   out_data_q, out_data_d;
  logic                 in_ready_q, in_ready_d;
  logic                 busy_q, busy_d;

  logic                 step_dir;
  logic [KEY_LEN-1:0]   step_key;
  logic                 cache_hit;
  logic [BLOCK_W-1:0]   enc_round;
  logic [BLOCK_W-1:0]   dec_round;

  // Key schedule runs backwards only while decrypt rounds are executing.
  assign step_dir = (state_q == RUN) && mode_q;

  present_key_step #(.KEY_LEN(KEY_LEN)) u_key_step (
    .key      (key_q),
    .counter  (cnt_q),
    .dir      (step_dir),
    .next_key (step_key)
  );

  assign cache_hit = (KEY_CACHE != 0) && cache_valid_q && (bus.in_key == cache_key_q);
  assign enc_round = p_layer(sbox_layer(data_q ^ key_q[KEY_LEN-1 -: BLOCK_W]));
  assign dec_round = inv_sbox_layer(inv_p_layer(data_q)) ^ step_key[KEY_LEN-1 -: BLOCK_W];

  // Next-state logic: acceptance, key expansion, rounds and result handoff.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    mode_d        = mode_q;
    data_d        = data_q;
    key_d         = key_q;
    cache_valid_d = cache_valid_q;
    cache_key_d   = cache_key_q;
    cache_k32_d   = cache_k32_q;
    out_valid_d   = out_valid_q;
    out_data_d    = out_data_q;

    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          mode_d = bus.in_mode;
          if (!bus.in_mode) begin
            data_d  = bus.in_data;
            key_d   = bus.in_key;
            cnt_d   = 5'd1;
            state_d = RUN;
          end else if (cache_hit) begin
            // K32 already known: strip the final whitening key right away.
            data_d  = bus.in_data ^ cache_k32_q[KEY_LEN-1 -: BLOCK_W];
            key_d   = cache_k32_q;
            cnt_d   = 5'(ROUNDS);
            state_d = RUN;
          end else begin
            // The cache entry is invalid until this expansion completes.
            data_d        = bus.in_data;
            key_d         = bus.in_key;
            cnt_d         = 5'd1;
            cache_valid_d = 1'b0;
            cache_key_d   = bus.in_key;
            state_d       = KEXP;
          end
        end
      end

      KEXP: begin
        key_d = step_key;
        if (cnt_q == 5'(ROUNDS)) begin
          data_d        = data_q ^ step_key[KEY_LEN-1 -: BLOCK_W];
          cache_valid_d = (KEY_CACHE != 0);
          cache_k32_d   = step_key;
          state_d       = RUN;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end

      RUN: begin
        key_d = step_key;
        if (!mode_q) begin
          if (cnt_q == 5'(ROUNDS)) begin
            data_d  = enc_round ^ step_key[KEY_LEN-1 -: BLOCK_W];
            state_d = DONE;
          end else begin
            data_d = enc_round;
            cnt_d  = cnt_q + 5'd1;
          end
        end else begin
          data_d = dec_round;
          if (cnt_q == 5'd1) begin
            state_d = DONE;
          end else begin
            cnt_d = cnt_q - 5'd1;
          end
        end
      end

      DONE: begin
        if (!out_valid_q) begin
          out_valid_d = 1'b1;
          out_data_d  = data_q;
        end else if (bus.out_ready) begin
          out_valid_d = 1'b0;
          cnt_d       = 5'd0;
          state_d     = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase

    in_ready_d = (state_d == IDLE);
    busy_d     = (state_d != IDLE);
  end

  // State and output registers; reset aborts any transaction in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      mode_q        <= 1'b0;
      data_q        <= '0;
      key_q         <= '0;
      cache_valid_q <= 1'b0;
      cache_key_q   <= '0;
      cache_k32_q   <= '0;
      out_valid_q   <= 1'b0;
      out_data_q    <= '0;
      in_ready_q    <= 1'b1;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      mode_q        <= mode_d;
      data_q        <= data_d;
      key_q         <= key_d;
      cache_valid_q <= cache_valid_d;
      cache_key_q   <= cache_key_d;
      cache_k32_q   <= cache_k32_d;
      out_valid_q   <= out_valid_d;
      out_data_q    <= out_data_d;
      in_ready_q    <= in_ready_d;
      busy_q        <= busy_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign busy          = busy_q;
  assign dbg_state     = state_q;

endmodule

// File: doc/present_codec_core.md
Name: present_codec_core

Overview:
- Iterative PRESENT block cipher engine. One engine handles both encryption and decryption, selected per transaction.
- Key length is parametrised (80 or 128 bits). Processes one round per clock.
- Uses valid/ready handshakes on input and output.
- Replaces the fixed 128-bit decrypt-only datapath. It sits between the IoT packet framer (input side) and the MAC/DM hashing stage (output side).

Parameters:
- KEY_LEN, 128, key width. Legal values are 80 or 128; any other value is an elaboration error.
- KEY_CACHE, 1. When 1, the final decryption round key is retained and reused when the key is unchanged.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  request present.
- in_ready  out  1  engine can accept a request (state IDLE).
- in_mode  in  1  0 = encrypt, 1 = decrypt.
- in_data  in  64  plaintext (encrypt) or ciphertext (decrypt).
- in_key  in  KEY_LEN  cipher key, MSB-first per PRESENT spec.
- out_valid  out  1  result available.
- out_ready  in  1  downstream accepts result.
- out_data  out  64  ciphertext or plaintext.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (rst_n=0 at posedge): state IDLE.
  - in_ready=1, out_valid=0, out_data=0, busy=0.
  - Round counter = 0, key-cache valid flag cleared.
  - Reset mid-operation aborts the transaction with no output.
- Acceptance: occurs on an edge where in_valid && in_ready. The engine captures in_mode, in_data and in_key, and in_ready drops the next cycle.
- States:
  - IDLE -> KEXP when decrypt and the cache misses.
  - IDLE -> RUN otherwise (encrypt, or decrypt with a cache hit).
  - KEXP -> RUN after the counter reaches 31.
  - RUN -> DONE after round 31.
  - DONE -> IDLE on out_valid && out_ready.
- KEXP: runs the forward key schedule from the captured key, 31 steps, one per cycle, with round counter 1..31. It ends holding K32 in the key register, and K32 is written to the cache together with the key.
- RUN, encrypt:
  - Each cycle: state ^= K_i[top 64], then S-layer, then P-layer, then forward key update using counter i.
  - i runs 1..31. On the final transition, state ^= K32.
- RUN, decrypt:
  - First cycle: state = in_data ^ K32.
  - Each cycle: inverse P-layer, then inverse S-layer, then inverse key update to K_i, then state ^= K_i[top 64].
  - i runs 31 down to 1.
- Key update for KEY_LEN=80:
  - rotate left 61.
  - S-box on [79:76].
  - [19:15] ^= counter.
- Key update for KEY_LEN=128:
  - rotate left 61.
  - S-box on [127:124] and [123:120].
  - [66:62] ^= counter.
- Inverse key update: the exact algebraic inverse of the forward update (undo the counter XOR, apply the inverse S-box(es), rotate right 61).
- Latency from the acceptance edge to out_valid high:
  - encrypt: 32 cycles.
  - decrypt, cache miss: 63 cycles.
  - decrypt, cache hit: 32 cycles.
- Cache hit condition: KEY_CACHE=1, cache valid, and in_key equals the cached key. When KEY_CACHE=0, every decrypt takes the cache-miss path.
- DONE: out_valid and out_data are held stable until out_ready. With out_ready already high, out_valid lasts exactly 1 cycle. in_ready returns to 1 on the cycle after the handshake; there is no same-cycle re-accept.
- in_valid while busy: ignored, not queued. Inputs may change freely after acceptance.
- out_ready low indefinitely: the engine stalls in DONE and in_ready stays 0.
- All arithmetic is XOR or bit permutation; the 5-bit round counter never exceeds 31.

Decomposition:
- Package present_pkg:
  - constants ROUNDS=31 and BLOCK_W=64.
  - SBOX and INV_SBOX 16x4 constant tables.
  - functions sbox_layer, inv_sbox_layer, p_layer, inv_p_layer.
  - state enum {IDLE, KEXP, RUN, DONE}.
- Sub-module present_key_step:
  - combinational.
  - parameter KEY_LEN.
  - inputs key, counter, dir.
  - output next key (forward or inverse update).
  - instantiated once in the core.

Test Plan:
- KEY_LEN=80, key=0, encrypt pt=0000000000000000 -> out_data=5579C1387B228445, out_valid exactly 32 cycles after acceptance.
- KEY_LEN=80, key=FFFFFFFFFFFFFFFFFFFF, decrypt ct=3333DCD3213210D2 -> FFFFFFFFFFFFFFFF after 63 cycles. An immediate second decrypt with the same key, ct=E72C46C0F5945049 -> 0000000000000000 after 32 cycles (cache hit). With KEY_CACHE=0 the second decrypt takes 63 cycles.
- KEY_LEN=128, key=0, encrypt pt=0 -> 96DB702A2E6900AF. Decrypting that result with the same key -> 0.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid. Pulse in_valid with new data during the stall -> out_data stable, in_ready=0, the new request is not taken. After out_ready=1, in_ready=1 the next cycle.
- Mid-run reset: assert rst_n=0 at round 15 of a decrypt -> next cycle in_ready=1, out_valid=0, busy=0. The next decrypt with the same key takes 63 cycles, because the cache was cleared.
- Random regression: 1000 random key/data/mode requests with random out_ready. The result matches the reference model, and decrypt(encrypt(x)) = x for every key.
